// File: rtl/fp_to_mont_pkg.sv
// Curve constants and shared types for the Fp -> Montgomery entry path (BLS12-381 build).
// Holds the field modulus, operand width, Montgomery radix exponent and the R mod p reference value.
// qpmm_fp_t is the QPMM operand type; results are zero-extended into it.
package fp_to_mont_pkg;

  // Fp element width and log2 of the Montgomery radix used by QPMM.
  localparam int FP_W   = 381;
  localparam int R_LOG2 = 384;

  // QPMM operand register type (wider than FP_W; upper bits carry zeros).
  typedef logic [383:0] qpmm_fp_t;

  localparam logic [383:0] MOD_384 =
    384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  // 2^384 mod p, the Montgomery form of 1.
  localparam logic [383:0] R_MOD_P_384 =
    384'h15f65ec3fa80e4935c071a97a256ec6d77ce5853705257455f48985753c758baebf4000bc40c0002760900000002fffd;

  // 2^FP_W < 2*MOD, so a single conditional subtraction canonicalises any FP_W-bit input.
  localparam logic [FP_W-1:0] MOD     = MOD_384[FP_W-1:0];
  localparam logic [FP_W-1:0] R_MOD_P = R_MOD_P_384[FP_W-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRERED = 2'd1,
    DBL    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fp_mod_dbl.sv
// Combinational modular doubling: y = 2x mod M for canonical x (x < M).
// Latency: 0 cycles (pure combinational, one W+1-bit compare and one subtract).
// Ports: x (canonical input), y (canonical output); no handshake, no backpressure.
module fp_mod_dbl
  import fp_to_mont_pkg::*;
#(
  parameter int           W = FP_W,
  parameter logic [W-1:0] M = MOD
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W:0]   dbl;
  logic [W-1:0] diff;

  assign dbl  = {x, 1'b0};
  // 2x - M < M < 2^W, so the subtraction can be done modulo 2^W.
  assign diff = dbl[W-1:0] - M;
  assign y    = (dbl >= {1'b0, M}) ? diff : dbl[W-1:0];

endmodule

// File: rtl/fp_to_mont.sv
// Converts an Fp integer a (0 <= a < 2^W) into Montgomery form a*R mod p by R_LOG2 modular doublings.
// Latency: accept edge is edge 0; out_valid high after edge N+2 (N = R_LOG2/STEPS); one operand in flight.
// Ports: in_valid/in_ready/in_data accept side, out_valid/out_ready/out_data result side; result held until consumed.
module fp_to_mont
  import fp_to_mont_pkg::*;
#(
  parameter int           W       = FP_W,
  parameter int           R_LOG2  = fp_to_mont_pkg::R_LOG2,
  parameter int           STEPS   = 8,
  parameter logic [W-1:0] MODULUS = MOD
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output qpmm_fp_t      out_data
);

  localparam int N  = R_LOG2 / STEPS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int QW = $bits(qpmm_fp_t);

  if ((R_LOG2 % STEPS) != 0) begin : g_bad_steps
    $error("fp_to_mont: R_LOG2 must be a multiple of STEPS");
  end
  if (QW <= W) begin : g_bad_width
    $error("fp_to_mont: qpmm_fp_t must be wider than W");
  end

  state_t          state, state_nxt;
  logic [W-1:0]    x, x_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  qpmm_fp_t        out_data_nxt;
  logic            out_valid_nxt;
  logic            in_ready_nxt;

  // STEPS chained doublings evaluated each DBL cycle.
  logic [W-1:0] chain [STEPS+1];
  assign chain[0] = x;

  for (genvar g = 0; g < STEPS; g++) begin : g_dbl
    fp_mod_dbl #(
      .W (W),
      .M (MODULUS)
    ) u_dbl (
      .x (chain[g]),
      .y (chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      x         <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      cnt       <= cnt_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      in_ready  <= in_ready_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    x_nxt         = x;
    cnt_nxt       = cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_nxt     = in_data;
          state_nxt = PRERED;
        end
      end
      PRERED: begin
        x_nxt     = (x >= MODULUS) ? (x - MODULUS) : x;
        cnt_nxt   = '0;
        state_nxt = DBL;
      end
      DBL: begin
        x_nxt   = chain[STEPS];
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(N - 1)) begin
          out_data_nxt = {{(QW-W){1'b0}}, chain[STEPS]};
          state_nxt    = DONE;
        end
      end
      DONE: begin
        // out_valid rises one cycle after out_data is loaded; the handshake
        // is only honoured once out_valid is actually visible.
        if (!out_valid) begin
          out_valid_nxt = 1'b1;
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Ready only after a full cycle in IDLE: low during reset, low on the
    // cycle right after a result is consumed, and dropped on acceptance.
    in_ready_nxt = (state == IDLE) && (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_fp_to_mont.sv
module tb_fp_to_mont;
  import fp_to_mont_pkg::*;

  localparam int W     = FP_W;
  localparam int QW    = $bits(qpmm_fp_t);
  localparam int STEPS = 8;
  localparam int N     = R_LOG2 / STEPS;
  localparam int NRAND = 200;
  localparam int NV    = 6;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  qpmm_fp_t      out_data;

  fp_to_mont #(
    .W      (W),
    .R_LOG2 (R_LOG2),
    .STEPS  (STEPS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]  id;
    logic [W-1:0] a;
    qpmm_fp_t     exp;
  } sb_t;

  typedef struct packed {
    logic [W-1:0] a;
    qpmm_fp_t     exp;
  } vec_t;

  sb_t  sbq[$];
  vec_t tbl[NV];
  int   next_id = 0;
  bit   seen = 1'b0;
  bit   rnd_done = 1'b0;

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic qpmm_fp_t ext(input logic [W-1:0] v);
    return {{(QW-W){1'b0}}, v};
  endfunction

  // Reference: (a * 2^R_LOG2) mod p by wide arithmetic.
  function automatic qpmm_fp_t model(input logic [W-1:0] a);
    logic [W+R_LOG2-1:0] t;
    logic [W+R_LOG2-1:0] m;
    t = {a, {R_LOG2{1'b0}}};
    m = {{R_LOG2{1'b0}}, MOD};
    t = t % m;
    return ext(t[W-1:0]);
  endfunction

  // Montgomery exit: z * 2^-R_LOG2 mod p by bit-serial halving.
  function automatic logic [W-1:0] mont_red(input qpmm_fp_t z);
    logic [W+1:0] acc;
    acc = z[W+1:0];
    for (int i = 0; i < R_LOG2; i++) begin
      if (acc[0]) acc = acc + {2'b00, MOD};
      acc = acc >> 1;
    end
    if (acc >= {2'b00, MOD}) acc = acc - {2'b00, MOD};
    return acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] a_mod_p(input logic [W-1:0] a);
    logic [W+1:0] t;
    t = {2'b00, a} % {2'b00, MOD};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_a();
    logic [QW-1:0] r;
    r = '0;
    for (int k = 0; k < QW/32; k++) r[k*32 +: 32] = $urandom();
    return r[W-1:0];
  endfunction

  // Scoreboard: each new result (first cycle out_valid is seen) is compared
  // against the queued expectation, the wide-arithmetic model, and MR().
  always @(negedge clk) begin
    sb_t e;
    if (!rstn) begin
      seen = 1'b0;
    end else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sbq.size() == 0) begin
        chk("unexpected_output", out_data, '0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("result%0d_data", e.id), out_data, e.exp);
        chk($sformatf("result%0d_model", e.id), out_data, model(e.a));
        chk($sformatf("result%0d_mont_exit", e.id), ext(mont_red(out_data)), ext(a_mod_p(e.a)));
      end
    end else if (!out_valid) begin
      seen = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [W-1:0] a, input qpmm_fp_t exp, input bit push);
    int guard;
    sb_t e;
    guard = 0;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", QW'(in_ready), QW'(1'b1));
    in_valid = 1'b1;
    in_data  = a;
    if (push) begin
      e.id  = next_id;
      e.a   = a;
      e.exp = exp;
      sbq.push_back(e);
    end
    next_id++;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand_a();
  endtask

  // Edges elapsed after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_wait", QW'(out_valid), QW'(1'b1));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || !in_ready) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", QW'(sbq.size()), '0);
  endtask

  initial begin
    int lat;
    int vhigh;
    qpmm_fp_t bp_exp;
    logic [W-1:0] bp_a;

    tbl[0] = '{a: W'(1),       exp: ext(R_MOD_P)};
    tbl[1] = '{a: MOD - 1'b1,  exp: ext(MOD - R_MOD_P)};
    tbl[2] = '{a: MOD,         exp: '0};
    tbl[3] = '{a: MOD + 1'b1,  exp: ext(R_MOD_P)};
    tbl[4] = '{a: {W{1'b1}},   exp: model({W{1'b1}})};
    tbl[5] = '{a: W'(2),       exp: model(W'(2))};

    rstn      = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rstn = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_out_valid", QW'(out_valid), '0);
    chk("reset_in_ready", QW'(in_ready), '0);
    chk("reset_out_data", out_data, '0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", QW'(in_ready), QW'(1'b1));

    // a = 0 with exact latency
    out_ready = 1'b1;
    send('0, '0, 1'b1);
    wait_valid(lat);
    chk("latency_a0", QW'(lat), QW'(N + 2));
    drain();

    // Table-driven vectors
    for (int i = 0; i < NV; i++) send(tbl[i].a, tbl[i].exp, 1'b1);
    drain();

    // Back-pressure: output held, in_ready low, extra input ignored
    out_ready = 1'b0;
    bp_a   = rand_a();
    bp_exp = model(bp_a);
    send(bp_a, bp_exp, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_valid", i), QW'(out_valid), QW'(1'b1));
      chk($sformatf("bp_hold%0d_in_ready", i), QW'(in_ready), '0);
      chk($sformatf("bp_hold%0d_data", i), out_data, bp_exp);
      if (i == 1) begin
        in_valid = 1'b1;
        in_data  = rand_a();
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", QW'(out_valid), '0);
    chk("bp_release_in_ready", QW'(in_ready), '0);
    @(negedge clk);
    chk("bp_ready_rise", QW'(in_ready), QW'(1'b1));
    vhigh = 0;
    repeat (N + 5) begin
      @(negedge clk);
      if (out_valid) vhigh++;
    end
    chk("bp_ignored_input", QW'(vhigh), '0);

    // Reset in the middle of DBL (counter = 20)
    send(W'(1), '0, 1'b0);
    repeat (21) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", QW'(out_valid), '0);
    chk("midrst_in_ready", QW'(in_ready), '0);
    chk("midrst_out_data", out_data, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready", QW'(in_ready), QW'(1'b1));
    send(W'(1), ext(R_MOD_P), 1'b1);
    wait_valid(lat);
    chk("midrst_latency", QW'(lat), QW'(N + 2));
    drain();

    // Randomised back-to-back operands with random output stalls
    fork
      begin
        logic [W-1:0] ra;
        for (int i = 0; i < NRAND; i++) begin
          ra = rand_a();
          send(ra, model(ra), 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
